bin_stream_source: RTL and testbench
====================================

BIN_STREAM_SOURCE -- requirements
Module: bin_stream_source

Interface
REQ-001 Parameter ADDR_W, default 9, width of bin address and index.
REQ-002 Parameter DATA_W, default 32, width of bin magnitude word.
REQ-003 Parameter READ_LAT, default 1, buffer read latency in cycles; legal range 1..3.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  one-cycle scan request.
REQ-007 first_bin, last_bin  in  ADDR_W each  inclusive scan bounds, sampled only on accepted go.
REQ-008 abort  in  1  synchronous scan cancel.
REQ-009 mem_addr  out  ADDR_W  read address to magnitude buffer.
REQ-010 mem_data  in  DATA_W  read data, valid READ_LAT cycles after mem_addr.
REQ-011 start  out  1  one-cycle pulse coincident with first streamed datum.
REQ-012 data_out  out  DATA_W  streamed magnitude.
REQ-013 index  out  ADDR_W  bin number of data_out.
REQ-014 valid  out  1  data_out/index qualify this cycle.
REQ-015 busy  out  1  scan in progress.
REQ-016 done  out  1  one-cycle pulse at scan completion.
REQ-017 err  out  1  bounds error flag, held until next accepted go.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, DRAIN, FIN.
REQ-019 go in IDLE SHALL be accepted; go in any other state SHALL be ignored.
REQ-020 Accepted go at cycle T with first_bin<=last_bin: ISSUE at T+1, mem_addr=first_bin at T+1, incrementing by 1 each cycle through last_bin, no gaps.
REQ-021 After issuing last_bin, FSM SHALL enter DRAIN for READ_LAT cycles, then FIN for one cycle, then IDLE.
REQ-022 valid/index SHALL travel a READ_LAT-deep shift pipeline beside each address; data_out=mem_data registered-through only if READ_LAT path requires, so data_out, index, valid are aligned at T+1+READ_LAT+k for bin first_bin+k.
REQ-023 start SHALL be high exactly on the valid cycle carrying first_bin, low otherwise.
REQ-024 Stream SHALL be contiguous: valid high for exactly last_bin-first_bin+1 consecutive cycles.
REQ-025 done SHALL pulse in FIN, the cycle after the last valid datum; busy SHALL be high from T+1 through the FIN cycle inclusive.
REQ-026 first_bin==last_bin: exactly one datum, start and valid together, done the following cycle.
REQ-027 first_bin>last_bin: no reads, no valid, err set at T+1, FSM goes IDLE->FIN, done pulses at T+1, busy high only at T+1.
REQ-028 Address counter SHALL not wrap; last_bin=2^ADDR_W-1 terminates normally.
REQ-029 abort in any non-IDLE state SHALL return FSM to IDLE next cycle, clear the valid pipeline (no further valid/start), suppress done; abort in IDLE has no effect.
REQ-030 abort and go in the same cycle while IDLE: go accepted, abort ignored.
REQ-031 err SHALL clear on the next accepted go.
REQ-032 When valid is low, data_out and index SHALL hold their last values; mem_addr SHALL hold its last value outside ISSUE.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, start=0, valid=0, busy=0, done=0, err=0, mem_addr=0, index=0, data_out=0, pipeline cleared.
REQ-034 Reset mid-scan SHALL discard the scan; no done after release.
REQ-035 First go is acceptable the first clock edge after rst_n deasserts.

Structure
REQ-036 FSM state encoding and the READ_LAT legal-range constants SHALL reside in the shared project package.
REQ-037 The valid/index delay line SHALL be one sub-module, bin_delay_line, parameterised by depth and width.

Verification
REQ-038 READ_LAT=1, go with first=10,last=13, buffer word n = 100+n -> valid at T+2..T+5 with index 10..13, data 110..113, start at T+2, done at T+6, busy T+1..T+6.
REQ-039 READ_LAT=3, first=last=0 -> single valid with start at T+4, done at T+5.
REQ-040 first=20,last=5 -> no valid, err=1 and done at T+1; next go with first=0,last=1 clears err.
REQ-041 first=0,last=511, abort at T+100 -> valid stops by T+101, no done, busy low at T+101; go at T+102 accepted.
REQ-042 go re-asserted during scan and rst_n pulsed low mid-scan -> extra go ignored; reset forces all outputs to 0 asynchronously, no done afterwards.

Source files
------------

// File: rtl/bin_stream_source_pkg.sv
// Shared definitions for the bin streaming source: FSM encoding and read-latency limits.
package bin_stream_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

  // Drain down-counter width; must hold READ_LAT_MAX-1.
  localparam int DRAIN_CNT_W = 2;

endpackage

// File: rtl/bin_stream_source_delay.sv
// Fixed-depth shift line carrying a valid flag and a side-band word; flush kills in-flight valids.
module bin_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] v_sr;
  logic [WIDTH-1:0] d_sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr <= '0;
      for (int i = 0; i < DEPTH; i++) d_sr[i] <= '0;
    end else begin
      if (flush) begin
        v_sr <= '0;
      end else begin
        v_sr[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) v_sr[i] <= v_sr[i-1];
      end
      d_sr[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) d_sr[i] <= d_sr[i-1];
    end
  end

  assign out_valid = v_sr[DEPTH-1];
  assign out_data  = d_sr[DEPTH-1];

endmodule

// File: rtl/bin_stream_source.sv
// Scans an inclusive bin range out of a magnitude buffer and streams the words with index/start/done framing.
//
// state | meaning
// IDLE  | waiting for go
// ISSUE | presenting one read address per cycle, first_bin..last_bin
// DRAIN | letting the last READ_LAT reads return
// FIN   | one-cycle done pulse (also the immediate exit for an inverted range)
module bin_stream_source
  import bin_stream_source_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] first_bin,
  input  logic [ADDR_W-1:0] last_bin,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              start,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] index,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
    $error("bin_stream_source: READ_LAT out of range");
  end

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(READ_LAT - 1);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr_q, last_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   err_q, first_pend;
  logic [ADDR_W-1:0]      index_hold;
  logic [DATA_W-1:0]      data_hold;

  logic                   flush, dl_valid, dl_first;
  logic [ADDR_W-1:0]      dl_index;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (go) state_nxt = (first_bin <= last_bin) ? ST_ISSUE : ST_FIN;
      ST_ISSUE: if (addr_q == last_q) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == '0) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      drain_cnt  <= '0;
      err_q      <= 1'b0;
      first_pend <= 1'b0;
      index_hold <= '0;
      data_hold  <= '0;
    end else begin
      state <= state_nxt;
      if (dl_valid) begin
        index_hold <= dl_index;
        data_hold  <= mem_data;
      end
      unique case (state)
        ST_IDLE: if (go) begin
          err_q <= (first_bin > last_bin);
          if (first_bin <= last_bin) begin
            addr_q     <= first_bin;
            last_q     <= last_bin;
            first_pend <= 1'b1;
          end
        end
        ST_ISSUE: begin
          first_pend <= 1'b0;
          // Stop at last_bin rather than wrapping; abort freezes the address.
          if (!abort) begin
            if (addr_q != last_q) addr_q <= addr_q + ADDR_W'(1);
            else                  drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  assign flush = abort && (state != ST_IDLE);

  bin_delay_line #(
    .DEPTH (READ_LAT),
    .WIDTH (ADDR_W + 1)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (state == ST_ISSUE),
    .in_data   ({first_pend, addr_q}),
    .out_valid (dl_valid),
    .out_data  ({dl_first, dl_index})
  );

  // Read data arrives exactly when the delayed valid does, so it passes straight through.
  assign mem_addr = addr_q;
  assign valid    = dl_valid;
  assign start    = dl_valid & dl_first;
  assign index    = dl_valid ? dl_index : index_hold;
  assign data_out = dl_valid ? mem_data : data_hold;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_FIN);
  assign err      = err_q;

endmodule

// File: tb/tb_bin_stream_source.sv
// Directed bench for bin_stream_source: one instance at READ_LAT=1, one at READ_LAT=3, buffer word n = 100+n.
module tb_bin_stream_source;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        go1 = 0, abort1 = 0, go2 = 0, abort2 = 0;
  logic [8:0]  first1 = 0, last1 = 0, first2 = 0, last2 = 0;
  logic [8:0]  addr1, addr2, index1, index2;
  logic [31:0] mdata1, mdata2, dout1, dout2, m2a, m2b;
  logic        start1, valid1, busy1, done1, err1;
  logic        start2, valid2, busy2, done2, err2;

  bin_stream_source #(.ADDR_W(9), .DATA_W(32), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1), .first_bin(first1), .last_bin(last1),
    .abort(abort1), .mem_addr(addr1), .mem_data(mdata1), .start(start1),
    .data_out(dout1), .index(index1), .valid(valid1), .busy(busy1),
    .done(done1), .err(err1));

  bin_stream_source #(.ADDR_W(9), .DATA_W(32), .READ_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .go(go2), .first_bin(first2), .last_bin(last2),
    .abort(abort2), .mem_addr(addr2), .mem_data(mdata2), .start(start2),
    .data_out(dout2), .index(index2), .valid(valid2), .busy(busy2),
    .done(done2), .err(err2));

  // Buffer models with the matching read latency.
  always_ff @(posedge clk) begin
    mdata1 <= 32'(addr1) + 32'd100;
    m2a    <= 32'(addr2) + 32'd100;
    m2b    <= m2a;
    mdata2 <= m2b;
  end

  typedef struct packed {
    logic busy, done, valid, start, err;
    logic [8:0]  index;
    logic [31:0] data;
    logic [8:0]  addr;
  } obs_t;

  typedef struct {
    bit sel;
    int f;
    int l;
    bit ab;
    int cnt;
    bit err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic obs_t get_obs(bit sel);
    obs_t o;
    if (sel) o = '{busy2, done2, valid2, start2, err2, index2, dout2, addr2};
    else     o = '{busy1, done1, valid1, start1, err1, index1, dout1, addr1};
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_go(bit sel, int f, int l, bit ab);
    @(negedge clk);
    if (sel) begin go2 = 1; first2 = 9'(f); last2 = 9'(l); abort2 = ab; end
    else     begin go1 = 1; first1 = 9'(f); last1 = 9'(l); abort1 = ab; end
    tick();
    go1 = 0; go2 = 0; abort1 = 0; abort2 = 0;
  endtask

  task automatic run_scan(int v, vec_t t);
    int rl, n, vcnt, idx;
    obs_t o;
    logic [4:0] ectl;
    rl = t.sel ? 3 : 1;
    n = t.cnt;
    vcnt = 0;
    drive_go(t.sel, t.f, t.l, t.ab);
    for (int c = 1; c <= n + rl + 3; c++) begin
      o = get_obs(t.sel);
      if (!t.err) begin
        ectl = {c <= n + rl + 1, c == n + rl + 1, c >= 1 + rl && c <= n + rl, c == 1 + rl, 1'b0};
      end else begin
        ectl = {c == 1, c == 1, 1'b0, 1'b0, 1'b1};
      end
      chk($sformatf("ctrl v%0d c%0d", v, c), 32'({o.busy, o.done, o.valid, o.start, o.err}), 32'(ectl));
      if (ectl[2]) begin
        idx = t.f + c - 1 - rl;
        chk($sformatf("index v%0d c%0d", v, c), 32'(o.index), 32'(idx));
        chk($sformatf("data v%0d c%0d", v, c), o.data, 32'(idx + 100));
      end
      if (!t.err && c <= n)
        chk($sformatf("addr v%0d c%0d", v, c), 32'(o.addr), 32'(t.f + c - 1));
      if (o.valid) vcnt++;
      tick();
    end
    chk($sformatf("vcount v%0d", v), 32'(vcnt), 32'(t.cnt));
  endtask

  vec_t vecs[8];
  obs_t o;
  int dcnt, vcnt;

  initial begin
    vecs[0] = '{0, 10, 13, 0, 4, 0};
    vecs[1] = '{0, 20, 5, 0, 0, 1};
    vecs[2] = '{0, 0, 1, 0, 2, 0};
    vecs[3] = '{0, 5, 5, 1, 1, 0};
    vecs[4] = '{0, 508, 511, 0, 4, 0};
    vecs[5] = '{1, 0, 0, 0, 1, 0};
    vecs[6] = '{1, 4, 7, 0, 4, 0};
    vecs[7] = '{0, 3, 2, 0, 0, 1};

    #12;
    o = get_obs(0);
    chk("reset dut1", 32'({o.busy, o.done, o.valid, o.start, o.err}), 0);
    chk("reset dut1 addr", 32'(o.addr), 0);
    o = get_obs(1);
    chk("reset dut2", 32'({o.busy, o.done, o.valid, o.start, o.err}), 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    for (int v = 0; v < 8; v++) run_scan(v, vecs[v]);

    // abort in IDLE: no effect, err from the inverted scan stays set
    abort1 = 1;
    tick();
    abort1 = 0;
    chk("idle abort busy", 32'(busy1), 0);
    chk("idle abort err", 32'(err1), 1);

    // long scan aborted at T+100
    drive_go(0, 0, 511, 0);
    for (int c = 1; c < 100; c++) tick();
    chk("pre-abort valid", 32'(valid1), 1);
    chk("pre-abort index", 32'(index1), 98);
    abort1 = 1;
    tick();
    abort1 = 0;
    chk("post-abort ctrl", 32'({busy1, done1, valid1, start1}), 0);
    tick();
    chk("post-abort idle", 32'({busy1, done1, valid1}), 0);
    go1 = 1; first1 = 0; last1 = 1;
    tick();
    go1 = 0;
    chk("go after abort busy", 32'(busy1), 1);
    chk("go after abort addr", 32'(addr1), 0);
    dcnt = 0;
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      dcnt += int'(done1);
      vcnt += int'(valid1);
      tick();
    end
    chk("go after abort dones", 32'(dcnt), 1);
    chk("go after abort valids", 32'(vcnt), 2);

    // extra go mid-scan ignored, then async reset mid-scan
    drive_go(0, 0, 20, 0);
    for (int c = 1; c < 5; c++) tick();
    go1 = 1; first1 = 30; last1 = 40;
    tick();
    go1 = 0;
    chk("extra go ignored addr", 32'(addr1), 5);
    chk("extra go ignored index", 32'(index1), 4);
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    o = get_obs(0);
    chk("async reset ctrl", 32'({o.busy, o.done, o.valid, o.start, o.err}), 0);
    chk("async reset index", 32'(o.index), 0);
    chk("async reset data", o.data, 0);
    chk("async reset addr", 32'(o.addr), 0);
    @(negedge clk);
    rst_n = 1;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      dcnt += int'(done1) + int'(busy1);
    end
    chk("no done after reset", 32'(dcnt), 0);

    // go on the first edge after reset release
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    go1 = 1; first1 = 2; last1 = 3;
    tick();
    go1 = 0;
    chk("first edge go busy", 32'(busy1), 1);
    chk("first edge go addr", 32'(addr1), 2);
    tick();
    chk("first edge go start", 32'({valid1, start1}), 3);
    chk("first edge go data", dout1, 102);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
